// File: rtl/rv32i_register_file_pkg.sv
// ----------------------------------------------------------------------------
// rv32i_register_file_pkg
// Core-wide definitions shared by the RV32I datapath:
//   XLEN       architectural register width
//   REG_IDX_W  register index width (32 integer registers)
//   REG_ZERO   index of the hardwired-zero register x0
//   reg_idx_t  register index type
//   xlen_t     register data type
// ----------------------------------------------------------------------------
package rv32i_register_file_pkg;

    localparam int XLEN      = 32;
    localparam int REG_IDX_W = 5;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;
    typedef logic [XLEN-1:0]      xlen_t;

    localparam reg_idx_t REG_ZERO = 5'd0;

endpackage : rv32i_register_file_pkg

// File: rtl/rv32i_register_file_if.sv
// ----------------------------------------------------------------------------
// rv32i_register_file_if
// Bundles the register-file access signals between decode/write-back and the
// register file.
//   rsW     destination (write) register index
//   rs1     read-port-1 register index
//   rs2     read-port-2 register index
//   RegWEn  write enable, sampled on the rising clock edge
//   rd      write data
//   data1   contents of register rs1
//   data2   contents of register rs2
// Modports:
//   master  the core side driving indices/write data
//   slave   the register file
// ----------------------------------------------------------------------------
interface rv32i_register_file_if;
    import rv32i_register_file_pkg::*;

    reg_idx_t rsW;
    reg_idx_t rs1;
    reg_idx_t rs2;
    logic     RegWEn;
    xlen_t    rd;
    xlen_t    data1;
    xlen_t    data2;

    modport master (
        output rsW,
        output rs1,
        output rs2,
        output RegWEn,
        output rd,
        input  data1,
        input  data2
    );

    modport slave (
        input  rsW,
        input  rs1,
        input  rs2,
        input  RegWEn,
        input  rd,
        output data1,
        output data2
    );

endinterface : rv32i_register_file_if

// File: rtl/rv32i_register_file.sv
// ----------------------------------------------------------------------------
// rv32i_register_file
// Integer register file of the RV32I single-cycle core.
//   - two combinational read ports (rs1 -> data1, rs2 -> data2)
//   - one synchronous write port (rsW, rd, RegWEn) on the rising clock edge
//   - x0 hardwired to zero
// Ports:
//   clk    rising-edge clock for all writes
//   rst_n  asynchronous active-low reset, clears every register
//   rf     register-file access bundle (slave side)
// Parameters:
//   REGF_WIDTH  register width in bits
//   SELECTORS   register index width; depth is 2**SELECTORS
// ----------------------------------------------------------------------------
module rv32i_register_file
    import rv32i_register_file_pkg::*;
#(
    parameter int REGF_WIDTH = XLEN,
    parameter int SELECTORS  = REG_IDX_W
) (
    input  logic                         clk,
    input  logic                         rst_n,
    rv32i_register_file_if.slave         rf
);

    localparam int DEPTH = 2 ** SELECTORS;

    logic [REGF_WIDTH-1:0] regs [DEPTH];
    logic [REGF_WIDTH-1:0] data1;
    logic [REGF_WIDTH-1:0] data2;

    // Write port: reset has priority, so a write coinciding with an asserted
    // rst_n is dropped. Entry 0 is never written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (rf.RegWEn && (rf.rsW != REG_ZERO)) begin
            regs[rf.rsW] <= rf.rd;
        end
    end

    // Read ports: no write bypass, a same-cycle write shows up after the edge.
    always_comb begin
        data1 = '0;
        if (rf.rs1 != REG_ZERO) begin
            data1 = regs[rf.rs1];
        end
    end

    always_comb begin
        data2 = '0;
        if (rf.rs2 != REG_ZERO) begin
            data2 = regs[rf.rs2];
        end
    end

    assign rf.data1 = data1;
    assign rf.data2 = data2;

endmodule : rv32i_register_file

// File: tb/tb_rv32i_register_file.sv
// ----------------------------------------------------------------------------
// tb_rv32i_register_file
// Directed-vector bench for rv32i_register_file. Stimulus pushes expected
// read-port values into a queue; a monitor pops and compares them against the
// DUT outputs whenever the stimulus signals that the outputs have settled.
// ----------------------------------------------------------------------------
module tb_rv32i_register_file;
    import rv32i_register_file_pkg::*;

    logic clk;
    logic rst_n;

    rv32i_register_file_if rf_if ();

    rv32i_register_file #(
        .REGF_WIDTH (32),
        .SELECTORS  (5)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rf    (rf_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string name;
        xlen_t e1;
        xlen_t e2;
    } exp_t;

    exp_t exp_q[$];
    event chk_ev;
    int   n_cmp = 0;
    int   n_bad = 0;

    // Monitor: consumes every queued expectation once the outputs are presented.
    initial begin
        exp_t e;
        forever begin
            @(chk_ev);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (rf_if.data1 !== e.e1) begin
                    n_bad++;
                    $display("FAIL %s data1: got %h expected %h", e.name, rf_if.data1, e.e1);
                end
                n_cmp++;
                if (rf_if.data2 !== e.e2) begin
                    n_bad++;
                    $display("FAIL %s data2: got %h expected %h", e.name, rf_if.data2, e.e2);
                end
            end
        end
    end

    task automatic check(input string name, input reg_idx_t r1, input reg_idx_t r2,
                         input xlen_t e1, input xlen_t e2);
        exp_t e;
        rf_if.rs1 = r1;
        rf_if.rs2 = r2;
        #1;
        e.name = name;
        e.e1   = e1;
        e.e2   = e2;
        exp_q.push_back(e);
        -> chk_ev;
        #1;
    endtask

    task automatic write_reg(input reg_idx_t idx, input xlen_t val);
        @(negedge clk);
        rf_if.rsW    = idx;
        rf_if.rd     = val;
        rf_if.RegWEn = 1'b1;
        @(posedge clk);
        #1;
        rf_if.RegWEn = 1'b0;
    endtask

    initial begin
        rst_n        = 1'b0;
        rf_if.rsW    = '0;
        rf_if.rs1    = '0;
        rf_if.rs2    = '0;
        rf_if.RegWEn = 1'b0;
        rf_if.rd     = '0;

        check("por_reset", 5'd1, 5'd2, 32'h0, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        check("post_reset", 5'd9, 5'd30, 32'h0, 32'h0);

        // Populate, then reset asynchronously between edges.
        write_reg(5'd10, 32'h1234_5678);
        write_reg(5'd31, 32'hCAFE_F00D);
        check("prefill", 5'd10, 5'd31, 32'h1234_5678, 32'hCAFE_F00D);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        rf_if.rs1 = 5'd10;
        rf_if.rs2 = 5'd31;
        #1;
        begin
            exp_t e;
            e.name = "async_reset_no_edge";
            e.e1   = 32'h0;
            e.e2   = 32'h0;
            exp_q.push_back(e);
            -> chk_ev;
        end
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            reg_idx_t a;
            reg_idx_t b;
            a = reg_idx_t'(i);
            b = reg_idx_t'(31 - i);
            check($sformatf("reset_sweep_%0d", i), a, b, 32'h0, 32'h0);
        end

        // x0 guard
        write_reg(5'd0, 32'hFFFF_00FF);
        check("x0_guard", 5'd0, 5'd0, 32'h0, 32'h0);

        // Write then read
        write_reg(5'd3, 32'hFFFF_00FF);
        check("write_read", 5'd3, 5'd1, 32'hFFFF_00FF, 32'h0);

        // Top index, then a disabled write must not disturb it
        write_reg(5'd31, 32'hA5A5_5A5A);
        check("top_index", 5'd3, 5'd31, 32'hFFFF_00FF, 32'hA5A5_5A5A);
        @(negedge clk);
        rf_if.rsW    = 5'd31;
        rf_if.rd     = 32'h0;
        rf_if.RegWEn = 1'b0;
        @(posedge clk);
        #1;
        check("wen_low_hold", 5'd31, 5'd31, 32'hA5A5_5A5A, 32'hA5A5_5A5A);

        // Read during write: old value before the edge, new value after
        write_reg(5'd5, 32'h0000_0001);
        @(negedge clk);
        rf_if.rsW    = 5'd5;
        rf_if.rd     = 32'h0000_0002;
        rf_if.RegWEn = 1'b1;
        check("rdw_before_edge", 5'd5, 5'd3, 32'h0000_0001, 32'hFFFF_00FF);
        @(posedge clk);
        #1;
        rf_if.RegWEn = 1'b0;
        check("rdw_after_edge", 5'd5, 5'd5, 32'h0000_0002, 32'h0000_0002);

        // Reset held across an edge overrides a same-cycle write
        @(negedge clk);
        rf_if.rsW    = 5'd7;
        rf_if.rd     = 32'hDEAD_BEEF;
        rf_if.RegWEn = 1'b1;
        rst_n        = 1'b0;
        @(posedge clk);
        #1;
        rf_if.RegWEn = 1'b0;
        #1;
        rst_n = 1'b1;
        check("reset_vs_write", 5'd7, 5'd3, 32'h0, 32'h0);

        // Writes work again after reset
        write_reg(5'd7, 32'hDEAD_BEEF);
        check("write_after_reset", 5'd7, 5'd5, 32'hDEAD_BEEF, 32'h0);

        #2;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_rv32i_register_file
